// File: rtl/sram_1rw1r_masked.sv
// 1RW + 1R single-clock SRAM with per-segment write masks, 1- or 2-cycle read
// latency, selectable read-during-write policy and a post-reset clear sequencer.
module sram_1rw1r_masked #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int WRITE_SIZE     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                csb0,
  input  logic                                web0,
  input  logic [(DATA_WIDTH/WRITE_SIZE)-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0]               addr0,
  input  logic [DATA_WIDTH-1:0]               din0,
  output logic [DATA_WIDTH-1:0]               dout0,
  output logic                                rvalid0,
  input  logic                                csb1,
  input  logic [ADDR_WIDTH-1:0]               addr1,
  output logic [DATA_WIDTH-1:0]               dout1,
  output logic                                rvalid1,
  output logic                                busy,
  output logic                                collision
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_WMASKS-1:0] m
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (m[i]) r[i*WRITE_SIZE +: WRITE_SIZE] = new_w[i*WRITE_SIZE +: WRITE_SIZE];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) state_d = RUN;
    end
  end

  logic                  busy_w, wr0, rd0, rd1, collide;
  logic [DATA_WIDTH-1:0] wr_word, rd0_word, rd1_word;

  assign busy_w   = (state_q == CLEAR);
  assign wr0      = !busy_w && !csb0 && !web0;
  assign rd0      = !busy_w && !csb0 &&  web0;
  assign rd1      = !busy_w && !csb1;
  assign collide  = wr0 && rd1 && (addr0 == addr1);
  assign wr_word  = merge_word(mem[addr0], din0, wmask0);
  assign rd0_word = mem[addr0];
  // Write-first forwards the merged word because the array update is not yet visible.
  assign rd1_word = ((WRITE_FIRST != 0) && collide) ? wr_word : mem[addr1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy_w)   mem[cnt_q] <= '0;
      else if (wr0) mem[addr0] <= wr_word;
    end
  end

  // Stage p0: read data and request flags captured at the request edge
  logic [DATA_WIDTH-1:0] rd0_p0, rd1_p0;
  logic                  vld0_p0, vld1_p0, coll_p0;

  always_ff @(posedge clk) begin
    if (rd0) rd0_p0 <= rd0_word;
    if (rd1) rd1_p0 <= rd1_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_p0 <= 1'b0;
      vld1_p0 <= 1'b0;
      coll_p0 <= 1'b0;
    end else begin
      vld0_p0 <= rd0;
      vld1_p0 <= rd1;
      coll_p0 <= collide;
    end
  end

  logic [DATA_WIDTH-1:0] last0, last1;
  logic                  last_vld0, last_vld1;

  if (READ_LATENCY == 2) begin : g_lat2
    // Stage p1: extra register for the two-cycle latency option
    logic [DATA_WIDTH-1:0] rd0_p1, rd1_p1;
    logic                  vld0_p1, vld1_p1;

    always_ff @(posedge clk) begin
      if (vld0_p0) rd0_p1 <= rd0_p0;
      if (vld1_p0) rd1_p1 <= rd1_p0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld0_p1 <= 1'b0;
        vld1_p1 <= 1'b0;
      end else begin
        vld0_p1 <= vld0_p0;
        vld1_p1 <= vld1_p0;
      end
    end

    assign last0     = rd0_p1;
    assign last1     = rd1_p1;
    assign last_vld0 = vld0_p1;
    assign last_vld1 = vld1_p1;
  end else begin : g_lat1
    assign last0     = rd0_p0;
    assign last1     = rd1_p0;
    assign last_vld0 = vld0_p0;
    assign last_vld1 = vld1_p0;
  end

  // Output stage: dout holds between completions
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
  logic                  rvalid0_q, rvalid1_q, collision_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout0_q     <= '0;
      dout1_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rvalid0_q   <= last_vld0;
      rvalid1_q   <= last_vld1;
      collision_q <= coll_p0;
      if (last_vld0) dout0_q <= last0;
      if (last_vld1) dout1_q <= last1;
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign collision = collision_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_sram_1rw1r_masked.sv
// Bench for sram_1rw1r_masked: two instances (latency 1 / read-first and
// latency 2 / write-first) driven in lockstep and compared to a word-level model.
module tb_sram_1rw1r_masked;

  logic       clk = 1'b0;
  logic       rst, csb0, web0, csb1;
  logic [1:0] wmask0;
  logic [3:0] addr0, addr1;
  logic [7:0] din0;
  logic [7:0] dout0_w [2];
  logic [7:0] dout1_w [2];
  logic       rvalid0_w [2];
  logic       rvalid1_w [2];
  logic       busy_w [2];
  logic       coll_w [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_1rw1r_masked #(.READ_LATENCY(1), .WRITE_FIRST(0)) u_l1_rf (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_w[0]), .rvalid0(rvalid0_w[0]), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_w[0]), .rvalid1(rvalid1_w[0]), .busy(busy_w[0]), .collision(coll_w[0]));

  sram_1rw1r_masked #(.READ_LATENCY(2), .WRITE_FIRST(1)) u_l2_wf (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_w[1]), .rvalid0(rvalid0_w[1]), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_w[1]), .rvalid1(rvalid1_w[1]), .busy(busy_w[1]), .collision(coll_w[1]));

  // Reference model: word array, remaining-clear count, and per-port result
  // schedule indexed by completion edge (instance k has latency k+1).
  logic [7:0] mm [16];
  int         busy_cnt = 0;
  int         clr_i = 0;
  int         e = 0;
  bit         sv [2][2][4];
  logic [7:0] sd [2][2][4];
  logic [7:0] edout [2][2];
  bit         erv [2][2];
  bit         ecoll, pcoll;

  task automatic model_edge();
    logic [7:0] old0, old1, merged;
    bit wr, r0, r1, cnow;
    int s;
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          edout[k][p] = 8'h00;
          erv[k][p]   = 1'b0;
          for (int j = 0; j < 4; j++) sv[k][p][j] = 1'b0;
        end
      ecoll    = 1'b0;
      pcoll    = 1'b0;
      busy_cnt = 16;
      clr_i    = 0;
    end else begin
      wr = 1'b0; r0 = 1'b0; r1 = 1'b0;
      if (busy_cnt > 0) begin
        mm[clr_i] = 8'h00;
        clr_i++;
        busy_cnt--;
      end else begin
        wr = !csb0 && !web0;
        r0 = !csb0 && web0;
        r1 = !csb1;
      end
      old0   = mm[addr0];
      old1   = mm[addr1];
      merged = old0;
      for (int i = 0; i < 2; i++) if (wmask0[i]) merged[i*4 +: 4] = din0[i*4 +: 4];
      cnow = wr && r1 && (addr0 == addr1);
      for (int k = 0; k < 2; k++) begin
        s = (e + k + 1) % 4;
        if (r0) begin sv[k][0][s] = 1'b1; sd[k][0][s] = old0; end
        if (r1) begin sv[k][1][s] = 1'b1; sd[k][1][s] = (k == 1 && cnow) ? merged : old1; end
      end
      if (wr) mm[addr0] = merged;
      s = e % 4;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          if (sv[k][p][s]) begin
            edout[k][p] = sd[k][p][s];
            erv[k][p]   = 1'b1;
            sv[k][p][s] = 1'b0;
          end else begin
            erv[k][p] = 1'b0;
          end
        end
      ecoll = pcoll;
      pcoll = cnow;
    end
    e++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d dout0", k), 32'(dout0_w[k]), 32'(edout[k][0]));
      chk($sformatf("u%0d rvalid0", k), 32'(rvalid0_w[k]), 32'(erv[k][0]));
      chk($sformatf("u%0d dout1", k), 32'(dout1_w[k]), 32'(edout[k][1]));
      chk($sformatf("u%0d rvalid1", k), 32'(rvalid1_w[k]), 32'(erv[k][1]));
      chk($sformatf("u%0d busy", k), 32'(busy_w[k]), 32'(busy_cnt > 0));
      chk($sformatf("u%0d collision", k), 32'(coll_w[k]), 32'(ecoll));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = 2'b00; addr0 = 4'h0; addr1 = 4'h0; din0 = 8'h00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
    step();
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy_w[0] === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();

    // Requests during clear must be ignored
    rst = 1'b0;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 8'h99; wmask0 = 2'b11;
    csb1 = 1'b0; addr1 = 4'd7;
    count_busy("busy_len_first");
    idle();

    for (int a = 0; a < 16; a++) wr(4'(a), 8'h5A ^ 8'(a * 17), 2'b11);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy("busy_len_preload");
    for (int a = 0; a < 16; a++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(a);
      csb1 = 1'b0; addr1 = 4'(15 - a);
      step();
    end
    idle();
    step();
    step();

    wr(4'd3, 8'hAB, 2'b11);
    wr(4'd3, 8'h5C, 2'b01);
    idle();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    step();
    idle();
    step();
    chk("masked_l1_data", 32'(dout0_w[0]), 32'h0000_00AC);
    chk("masked_l1_valid", 32'(rvalid0_w[0]), 32'd1);
    step();
    chk("masked_l2_data", 32'(dout0_w[1]), 32'h0000_00AC);

    wr(4'd0, 8'h11, 2'b11);
    wr(4'd1, 8'h22, 2'b11);
    wr(4'd2, 8'h33, 2'b11);
    idle();
    for (int a = 0; a < 3; a++) begin
      csb1 = 1'b0; addr1 = 4'(a);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("pipe_l2_hold", 32'(dout1_w[1]), 32'h0000_0033);

    wr(4'd5, 8'h0F, 2'b11);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 8'hF0; wmask0 = 2'b11;
    csb1 = 1'b0; addr1 = 4'd5;
    step();
    idle();
    step();
    chk("coll_flag_rf", 32'(coll_w[0]), 32'd1);
    chk("coll_flag_wf", 32'(coll_w[1]), 32'd1);
    chk("coll_read_first", 32'(dout1_w[0]), 32'h0000_000F);
    step();
    chk("coll_write_first", 32'(dout1_w[1]), 32'h0000_00F0);
    chk("coll_one_pulse", 32'(coll_w[0]), 32'd0);
    csb1 = 1'b0; addr1 = 4'd5;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    step();
    idle();
    rst = 1'b1;
    step();
    chk("rst_read_rv_l1", 32'(rvalid0_w[0]), 32'd0);
    chk("rst_read_rv_l2", 32'(rvalid0_w[1]), 32'd0);
    chk("rst_read_dout", 32'(dout0_w[1]), 32'd0);
    rst = 1'b0;
    count_busy("busy_len_midread");

    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 149) == 0);
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1) != 0;
      wmask0 = 2'($urandom_range(0, 3));
      din0   = 8'($urandom);
      csb1   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) != 0) begin
        addr0 = 4'($urandom_range(0, 3));
        addr1 = 4'($urandom_range(0, 3));
      end else begin
        addr0 = 4'($urandom);
        addr1 = 4'($urandom);
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
